// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared definitions for the intersection scheduler.
//
// Holds the two-bit light encodings, the controller state codes (which are
// also the externally visible phase codes), and the phase-code width.
// No ports; imported by the interface, the top level and the bench-facing
// decode.

package traffic_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

    // Code 7 is deliberately left unassigned; the FSM maps it back to HWY_G.
    typedef enum logic [PHASE_W-1:0] {
        HWY_G    = 3'd0,
        HWY_Y    = 3'd1,
        AR_H2C   = 3'd2,
        CNTRY_G  = 3'd3,
        CNTRY_Y  = 3'd4,
        AR_C2H   = 3'd5,
        PED_WALK = 3'd6
    } state_e;

endpackage

// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if -- sensor/lamp bundle of the intersection scheduler.
//
// Signals:
//   x        car waiting on the country road (level)
//   ped_req  pedestrian request (single-cycle pulse is enough)
//   hwy      highway light (traffic_pkg light encoding)
//   cntry    country light (same encoding)
//   walk     pedestrian walk lamp
//   phase    current controller state code
// Modports:
//   master   the environment: drives sensors, observes lamps
//   slave    the scheduler: observes sensors, drives lamps

interface intersection_scheduler_if;

    logic                             x;
    logic                             ped_req;
    logic [1:0]                       hwy;
    logic [1:0]                       cntry;
    logic                             walk;
    logic [traffic_pkg::PHASE_W-1:0]  phase;

    modport master (
        output x, ped_req,
        input  hwy, cntry, walk, phase
    );

    modport slave (
        input  x, ped_req,
        output hwy, cntry, walk, phase
    );

endinterface

// File: rtl/phase_timer.sv
// phase_timer -- cycles-in-current-state counter.
//
// Counts from 0 on the first cycle of a state, returns to 0 whenever the
// owner signals a state change, and sticks at all-ones instead of wrapping
// so a long dwell can never alias back onto a small threshold.
//
// Ports:
//   clk_i      clock, rising edge
//   clear_i    synchronous active-high reset
//   restart_i  state is changing on this edge; next count is 0
//   count_o    current count (registered)

module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler -- highway / country-road traffic light controller
// with an optional pedestrian walk phase.
//
// Moore FSM: every lamp and the phase code decode from the registered state
// only. The highway rests green; a waiting country car or a latched
// pedestrian request ends the highway green once its minimum has elapsed.
// Both directions always pass through yellow and an all-red clearance.
//
// Build option: define INTERSECTION_PED_EN to enable the pedestrian path.
// Without it ped_req is ignored, the request latch stays 0, PED_WALK can
// never be entered and walk is tied low; the port list is the same.
//
// Ports:
//   clk    clock, rising edge
//   clear  synchronous active-high reset (to HWY_G, timer 0, no request)
//   bus    intersection_scheduler_if.slave (x, ped_req in; hwy, cntry,
//          walk, phase out)

module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int Y2RDELAY  = 3,
    parameter int R2GDELAY  = 2,
    parameter int MIN_GREEN = 4,
    parameter int MAX_CNTRY = 8,
    parameter int WALK_CYC  = 6,
    parameter int CNT_W     = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    intersection_scheduler_if.slave  bus
);

    // Terminal counts: the timer reads N-1 on the last cycle of an N-cycle phase.
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y2R_LAST  = CNT_W'(Y2RDELAY - 1);
    localparam logic [CNT_W-1:0] R2G_LAST  = CNT_W'(R2GDELAY - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CNTRY - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYC - 1);

    state_e           state_q;
    state_e           state_d;
    logic             ped_pending_q;
    logic             ped_pending_d;
    logic [CNT_W-1:0] cnt;
    logic             state_change;

    assign state_change = (state_d != state_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_i     (clk),
        .clear_i   (clear),
        .restart_i (state_change),
        .count_o   (cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= HWY_G;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HWY_G: begin
                if ((cnt >= MIN_LAST) && (bus.x || ped_pending_q)) begin
                    state_d = HWY_Y;
                end
            end
            HWY_Y: begin
                if (cnt == Y2R_LAST) state_d = AR_H2C;
            end
            AR_H2C: begin
                // A waiting pedestrian is served ahead of the country road.
                if (cnt == R2G_LAST) state_d = ped_pending_q ? PED_WALK : CNTRY_G;
            end
            CNTRY_G: begin
                // Decision needs one green cycle first, so the minimum is 1.
                if (!bus.x || (cnt == MAX_LAST)) state_d = CNTRY_Y;
            end
            CNTRY_Y: begin
                if (cnt == Y2R_LAST) state_d = AR_C2H;
            end
            PED_WALK: begin
                if (cnt == WALK_LAST) state_d = AR_C2H;
            end
            AR_C2H: begin
                if (cnt == R2G_LAST) state_d = HWY_G;
            end
            default: state_d = HWY_G;
        endcase
    end

    // Pedestrian request latch. Entering PED_WALK clears it, and that clear
    // wins over a request arriving on the same edge.
`ifdef INTERSECTION_PED_EN
    always_comb begin
        ped_pending_d = ped_pending_q | bus.ped_req;
        if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
            ped_pending_d = 1'b0;
        end
    end
`else
    logic unused_ped;
    assign unused_ped    = bus.ped_req;
    assign ped_pending_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end

    // Output decode (registered state only)
    always_comb begin
        bus.hwy   = LIGHT_RED;
        bus.cntry = LIGHT_RED;
        bus.walk  = 1'b0;
        bus.phase = state_q;
        case (state_q)
            HWY_G:   bus.hwy   = LIGHT_GREEN;
            HWY_Y:   bus.hwy   = LIGHT_YELLOW;
            CNTRY_G: bus.cntry = LIGHT_GREEN;
            CNTRY_Y: bus.cntry = LIGHT_YELLOW;
            PED_WALK: begin
`ifdef INTERSECTION_PED_EN
                bus.walk = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler -- directed, table-driven bench for
// intersection_scheduler at default parameters. Expected lamp and phase
// values are hand-derived per cycle; pedestrian expectations follow
// whether INTERSECTION_PED_EN is defined for the build.

module tb_intersection_scheduler;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    intersection_scheduler_if bus ();

    intersection_scheduler dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic       clr;
        logic       x;
        logic       ped;
        logic [1:0] hwy;
        logic [1:0] cntry;
        logic       walk;
        logic [2:0] ph;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic add(input int n, input logic c, input logic xi, input logic p,
                       input logic [1:0] h, input logic [1:0] cn,
                       input logic w, input logic [2:0] ph);
        vec_t v;
        v.clr = c; v.x = xi; v.ped = p;
        v.hwy = h; v.cntry = cn; v.walk = w; v.ph = ph;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive inputs at the falling edge, let one rising edge happen, sample 1ns later.
    task automatic step(input string nm, input logic c, input logic xi, input logic p,
                        input logic [1:0] eh, input logic [1:0] ec,
                        input logic ew, input logic [2:0] ep);
        @(negedge clk);
        clear       = c;
        bus.x       = xi;
        bus.ped_req = p;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ({bus.hwy, bus.cntry, bus.walk, bus.phase} !== {eh, ec, ew, ep}) begin
            errors++;
            $display("FAIL %s cyc %0d: got hwy=%b cntry=%b walk=%b phase=%0d, want hwy=%b cntry=%b walk=%b phase=%0d",
                     nm, cyc, bus.hwy, bus.cntry, bus.walk, bus.phase, eh, ec, ew, ep);
        end
        checks++;
        if (bus.hwy !== RED && bus.cntry !== RED) begin
            errors++;
            $display("FAIL %s conflict cyc %0d: got hwy=%b cntry=%b, want at least one RED",
                     nm, cyc, bus.hwy, bus.cntry);
        end
    endtask

    task automatic rep(input int n, input string nm, input logic c, input logic xi,
                       input logic p, input logic [1:0] eh, input logic [1:0] ec,
                       input logic ew, input logic [2:0] ep);
        for (int i = 0; i < n; i++) step(nm, c, xi, p, eh, ec, ew, ep);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        clear       = 1'b1;
        bus.x       = 1'b0;
        bus.ped_req = 1'b0;

        // Reset held, then idle highway green
        add(5,  1, 0, 0, GRN, RED, 0, 0);
        add(10, 0, 0, 0, GRN, RED, 0, 0);
        // Country car held: full cycle at maximum country green
        add(3, 0, 1, 0, YEL, RED, 0, 1);
        add(2, 0, 1, 0, RED, RED, 0, 2);
        add(8, 0, 1, 0, RED, GRN, 0, 3);
        add(3, 0, 1, 0, RED, YEL, 0, 4);
        add(2, 0, 1, 0, RED, RED, 0, 5);
        // Car still waiting: highway gets exactly its minimum green
        add(4, 0, 1, 0, GRN, RED, 0, 0);
        add(3, 0, 1, 0, YEL, RED, 0, 1);
        add(2, 0, 1, 0, RED, RED, 0, 2);
        // Car leaves after 3 country green cycles
        add(3, 0, 1, 0, RED, GRN, 0, 3);
        add(3, 0, 0, 0, RED, YEL, 0, 4);
        add(2, 0, 0, 0, RED, RED, 0, 5);
        add(6, 0, 0, 0, GRN, RED, 0, 0);
        // Car present from the first cycle after reset release
        add(2, 1, 0, 0, GRN, RED, 0, 0);
        add(3, 0, 1, 0, GRN, RED, 0, 0);
        add(3, 0, 1, 0, YEL, RED, 0, 1);
        add(2, 0, 1, 0, RED, RED, 0, 2);
        add(2, 0, 1, 0, RED, GRN, 0, 3);
        // Reset mid country green dominates a waiting car
        add(1, 1, 1, 0, GRN, RED, 0, 0);
        add(3, 0, 0, 0, GRN, RED, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step("table", tbl[i].clr, tbl[i].x, tbl[i].ped,
                 tbl[i].hwy, tbl[i].cntry, tbl[i].walk, tbl[i].ph);
        end

        // Pedestrian pulse with no traffic; a second request on the walk-entry
        // edge must be absorbed, so the highway then rests green.
        rep(2, "ped_rst", 1, 0, 0, GRN, RED, 0, 0);
`ifdef INTERSECTION_PED_EN
        step("ped_req",   0, 0, 1, GRN, RED, 0, 0);
        rep(2, "ped_ming", 0, 0, 0, GRN, RED, 0, 0);
        rep(3, "ped_yel",  0, 0, 0, YEL, RED, 0, 1);
        rep(2, "ped_ar1",  0, 0, 0, RED, RED, 0, 2);
        step("ped_walk0", 0, 0, 1, RED, RED, 1, 6);
        rep(5, "ped_walk", 0, 0, 0, RED, RED, 1, 6);
        rep(2, "ped_ar2",  0, 0, 0, RED, RED, 0, 5);
        rep(8, "ped_rest", 0, 0, 0, GRN, RED, 0, 0);
`else
        step("ped_req",   0, 0, 1, GRN, RED, 0, 0);
        rep(23, "ped_off", 0, 0, 0, GRN, RED, 0, 0);
`endif

        // Car and pedestrian together: pedestrian first, car after next min green
        rep(2, "both_rst", 1, 0, 0, GRN, RED, 0, 0);
        step("both_req",  0, 1, 1, GRN, RED, 0, 0);
        rep(2, "both_ming", 0, 1, 0, GRN, RED, 0, 0);
        rep(3, "both_yel",  0, 1, 0, YEL, RED, 0, 1);
        rep(2, "both_ar1",  0, 1, 0, RED, RED, 0, 2);
`ifdef INTERSECTION_PED_EN
        rep(6, "both_walk", 0, 1, 0, RED, RED, 1, 6);
        rep(2, "both_ar2",  0, 1, 0, RED, RED, 0, 5);
        rep(4, "both_hg",   0, 1, 0, GRN, RED, 0, 0);
        rep(3, "both_yel2", 0, 1, 0, YEL, RED, 0, 1);
        rep(2, "both_ar3",  0, 1, 0, RED, RED, 0, 2);
        step("both_cg",   0, 1, 0, RED, GRN, 0, 3);
`else
        rep(8, "both_cg",   0, 1, 0, RED, GRN, 0, 3);
        step("both_cy",   0, 1, 0, RED, YEL, 0, 4);
`endif

        // Reset during country green with a request latched: no walk afterwards
        rep(2, "clr_rst", 1, 0, 0, GRN, RED, 0, 0);
        rep(3, "clr_hg",  0, 1, 0, GRN, RED, 0, 0);
        rep(3, "clr_yel", 0, 1, 0, YEL, RED, 0, 1);
        rep(2, "clr_ar",  0, 1, 0, RED, RED, 0, 2);
        step("clr_cgp", 0, 1, 1, RED, GRN, 0, 3);
        rep(2, "clr_cg",  0, 1, 0, RED, GRN, 0, 3);
        step("clr_mid", 1, 1, 0, GRN, RED, 0, 0);
        rep(12, "clr_after", 0, 0, 0, GRN, RED, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter Y2RDELAY, default 3: yellow-phase length in clk cycles (>=1).
REQ-002 Parameter R2GDELAY, default 2: all-red clearance length in clk cycles (>=1).
REQ-003 Parameter MIN_GREEN, default 4: minimum highway green in clk cycles (>=1).
REQ-004 Parameter MAX_CNTRY, default 8: maximum country green in clk cycles (>=1).
REQ-005 Parameter WALK_CYC, default 6: pedestrian walk length in clk cycles (>=1).
REQ-006 Parameter CNT_W, default 4: phase-timer width; every delay parameter SHALL be <= 2**CNT_W.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 clear  input  1  reset; synchronous, active-high.
REQ-009 x  input  1  country-road car sensor; level, 1 = car waiting.
REQ-010 ped_req  input  1  pedestrian request; a 1-cycle pulse suffices.
REQ-011 hwy  output  2  highway light: RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
REQ-012 cntry  output  2  country light, same encoding.
REQ-013 walk  output  1  pedestrian walk lamp.
REQ-014 phase  output  3  current state code (REQ-016).

Function
REQ-015 Moore FSM; hwy, cntry, walk, phase decode from the registered state only; no input-to-output combinational path.
REQ-016 States/codes: HWY_G=0, HWY_Y=1, AR_H2C=2, CNTRY_G=3, CNTRY_Y=4, AR_C2H=5, PED_WALK=6; codes 7 and unused SHALL recover to HWY_G on next edge.
REQ-017 Lights: HWY_G hwy=GREEN; HWY_Y hwy=YELLOW; CNTRY_G cntry=GREEN; CNTRY_Y cntry=YELLOW; every other light RED; walk=1 only in PED_WALK.
REQ-018 Phase timer counts cycles spent in current state from 0, clears to 0 on every state change, saturates at all-ones.
REQ-019 ped_pending latch: set by ped_req=1, cleared on entry to PED_WALK; ped_req coincident with that entry is absorbed (cleared).
REQ-020 HWY_G -> HWY_Y when timer >= MIN_GREEN-1 and (x or ped_pending); otherwise stay; green never shorter than MIN_GREEN cycles.
REQ-021 HWY_Y -> AR_H2C when timer == Y2RDELAY-1.
REQ-022 AR_H2C -> PED_WALK when timer == R2GDELAY-1 and ped_pending, else -> CNTRY_G.
REQ-023 CNTRY_G -> CNTRY_Y when x==0 or timer == MAX_CNTRY-1; at least one green cycle always granted.
REQ-024 CNTRY_Y -> AR_C2H when timer == Y2RDELAY-1.
REQ-025 PED_WALK -> AR_C2H when timer == WALK_CYC-1.
REQ-026 AR_C2H -> HWY_G when timer == R2GDELAY-1.
REQ-027 hwy and cntry SHALL never both be non-RED in the same cycle.
REQ-028 Pedestrian served before country when both pending; country car waits for next HWY_G min-green.

Reset
REQ-029 clear=1 at a rising edge: state=HWY_G, timer=0, ped_pending=0; outputs hwy=GREEN, cntry=RED, walk=0, phase=0 after that edge.
REQ-030 clear dominates all inputs and applies mid-phase identically; held clear keeps reset values.

Configuration
REQ-031 Macro INTERSECTION_PED_EN: defined -> pedestrian path per REQ-019/022/025; undefined -> ped_req ignored, ped_pending held 0, PED_WALK unreachable, walk tied 0; port list unchanged.

Structure
REQ-032 Package traffic_pkg holds light encodings, state codes, and phase-code width.
REQ-033 Sub-module phase_timer (CNT_W-bit, clear-on-change, saturating) instantiated once.

Verification (default parameters)
REQ-034 clear=1 for 5 cycles, x=0 -> hwy=2'b10, cntry=2'b00, walk=0, phase=0 every cycle, and hold while x=0.
REQ-035 x=1 held from cycle 10 after clear release -> hwy YELLOW 3 cycles, both RED 2, cntry GREEN 8 (max), cntry YELLOW 3, both RED 2, hwy GREEN.
REQ-036 x=1 at first cycle after clear release -> hwy stays GREEN 4 cycles total before YELLOW.
REQ-037 x dropped after 3 cntry GREEN cycles -> cntry YELLOW from next edge.
REQ-038 1-cycle ped_req, x=0, macro defined -> after min green: hwy YELLOW 3, all RED 2, walk=1 for 6 with both RED, all RED 2, hwy GREEN; macro undefined -> hwy GREEN throughout.
REQ-039 clear pulsed during CNTRY_G with ped_pending=1 -> next edge hwy GREEN, cntry RED, pending cleared, no later walk.
